bird_column: RTL and testbench
==============================

# bird_column

Parametrised bird column for the Flappy Bird LED matrix. It replaces the per-LED bird-light cells with a single block that tracks the bird's row in one column of ROWS LEDs. Each game tick the block applies flap lift or gravity fall, drives the column's one-hot LED vector, detects a floor crash and freezes on game over. It sits between the key-input conditioning (flap pulse), the game tick divider (enable) and the LED driver / pipe collision logic.

## Interface
- ROWS, 8: LEDs in the column; row 0 is the bottom (floor).
- FLAP_ROWS, 2: rows gained per flap.
- GRAVITY_TICKS, 3: enable ticks without a flap before the bird falls one row.
- START_ROW, ROWS/2: bird row after reset.
- clk  in  1  system clock; one clock only.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  game tick, one clk wide; all motion happens only on ticks.
- flap  in  1  single-cycle key-press pulse; may arrive on any clk.
- game_over  in  1  level input from pipe collision; freezes the bird.
- lights  out  ROWS  one-hot; lights[row] = 1.
- row  out  $clog2(ROWS)  current bird row.
- crashed  out  1  sticky; bird hit the floor.
- state  out  bird_state_t  IDLE / FLY / DEAD.

## Operation
- Reset values: row = START_ROW, lights = 1 << START_ROW, crashed = 0, state = IDLE, gravity count = 0, flap pending = 0.
- Flap latch: a flap pulse sets pending. Pending clears when it is consumed on a tick, and on entry to DEAD.
  - flap and enable in the same cycle counts as a flap on that tick.
  - Multiple flaps between ticks collapse to one.
- IDLE:
  - The bird hovers with no gravity.
  - A tick with a flap pending → FLY, and the flap is applied on that same tick.
- FLY, on a tick with a flap pending:
  - row = min(row + FLAP_ROWS, ROWS-1); the ceiling saturates and is not fatal.
  - gravity count = 0.
- FLY, on a tick with no flap pending:
  - If gravity count == GRAVITY_TICKS-1: count = 0 and the bird takes a fall step.
    - Fall step with row > 0: row = row - 1.
    - Fall step with row == 0: crashed = 1, state → DEAD, row stays 0.
  - Otherwise count = count + 1.
- DEAD: row, lights and count are held. Only reset exits.
- game_over:
  - Sampled every clk, independent of enable.
  - game_over = 1 → DEAD on the next edge from any state.
  - Has priority over any flap or gravity on that same edge.
  - crashed is not set by game_over.
- enable = 0: state, row and count are held; only the flap latch updates.

## Timing
- All outputs are registered. lights and row change on the clk edge that samples enable = 1 (one-cycle latency from the tick).
- A flap pulse in cycle t, with the next tick in cycle t+k (k ≥ 0), moves the bird at the edge ending cycle t+k.
- crashed and state = DEAD rise on the same edge.
- Reset asserted mid-flight clears everything asynchronously. The first tick after release is processed normally.
- Parameter legality is checked at elaboration and elaboration fails if violated:
  - ROWS ≥ 2
  - 1 ≤ FLAP_ROWS < ROWS
  - GRAVITY_TICKS ≥ 1
  - START_ROW < ROWS

## Structure
- Shared package bird_pkg:
  - bird_state_t enum {IDLE, FLY, DEAD}.
  - row-width helper function ROW_W(rows) = $clog2(rows).
- One sub-module, gravity_counter:
  - Counts enable ticks modulo GRAVITY_TICKS.
  - Inputs: clear (on flap) and hold (in IDLE/DEAD).
  - Output: a one-cycle fall_due pulse.
- Top level holds the state register, flap latch, row register and one-hot decode.

## Test plan
All scenarios use ROWS=8, FLAP_ROWS=2, GRAVITY_TICKS=3, START_ROW=4, with enable pulsed every 4 clk.
- Reset, then 10 ticks with no flap → state IDLE, row 4, lights 8'b0001_0000, crashed 0.
- Flap pulse 2 clk before a tick → FLY and row 6 on that tick. Next 3 ticks with no flap → row 5 after the 3rd tick.
- Start at row 6 and flap twice on consecutive ticks → row 7 saturated after the first flap, still 7 after the second; state stays FLY.
- FLY at row 1 with no flaps → row 0 after 3 ticks. After 3 more ticks: crashed 1, state DEAD, lights 8'b0000_0001. Further flaps and ticks cause no change.
- Assert game_over for 1 clk between ticks at row 5 → DEAD next edge with crashed 0. A flap in the same cycle is ignored and row stays 5.
- Assert reset asynchronously mid-clock in FLY at row 2 → outputs go immediately to row 4, IDLE, crashed 0.
- Flap and enable in the same cycle from IDLE → row 6 on that edge.

Source files
------------

// File: rtl/bird_pkg.sv
// Shared types and helpers for the bird column.
//   bird_state_t : IDLE (hovering, pre-game), FLY (gravity active), DEAD (frozen)
//   ROW_W(rows)  : width of a row index for a column of `rows` LEDs
package bird_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FLY  = 2'd1,
        DEAD = 2'd2
    } bird_state_t;

    function automatic int ROW_W(input int rows);
        return $clog2(rows);
    endfunction

endpackage

// File: rtl/bird_column_if.sv
// Game-side bundle for one bird column.
//   enable    : game tick, one clk wide
//   flap      : single-cycle key-press pulse
//   game_over : level from pipe collision logic
//   lights    : one-hot LED column, bit 0 is the floor
//   row       : current bird row
//   crashed   : sticky floor-crash flag
//   state     : IDLE / FLY / DEAD
// master drives the game inputs; slave is the bird column.
interface bird_column_if import bird_pkg::*; #(
    parameter int ROWS = 8
) ();

    logic                   enable;
    logic                   flap;
    logic                   game_over;
    logic [ROWS-1:0]        lights;
    logic [ROW_W(ROWS)-1:0] row;
    logic                   crashed;
    bird_state_t            state;

    modport master (
        output enable, flap, game_over,
        input  lights, row, crashed, state
    );

    modport slave (
        input  enable, flap, game_over,
        output lights, row, crashed, state
    );

endinterface

// File: rtl/bird_column_gravity_counter.sv
// Gravity tick counter: counts enable ticks modulo GRAVITY_TICKS.
//   clk, reset : clock, async active-high reset
//   tick       : game tick
//   clear      : a flap is being applied on this tick; restart the count
//   hold       : bird not under gravity (IDLE/DEAD or game over); freeze count
//   fall_due   : one-cycle pulse on the tick where the bird should drop a row
module gravity_counter #(
    parameter int GRAVITY_TICKS = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic clear,
    input  logic hold,
    output logic fall_due
);

    localparam int CW = (GRAVITY_TICKS > 1) ? $clog2(GRAVITY_TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(GRAVITY_TICKS - 1);

    logic [CW-1:0] count;
    logic          atLast;

    assign atLast   = (count == LAST);
    assign fall_due = tick & ~hold & ~clear & atLast;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (tick && !hold) begin
            if (clear || atLast) count <= '0;
            else                 count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/bird_column.sv
// Bird column for the Flappy Bird LED matrix: tracks the bird's row in one
// column of ROWS LEDs, applies flap lift / gravity fall on game ticks,
// detects a floor crash and freezes on game over.
//   clk, reset : system clock, async active-high reset
//   bus        : bird_column_if.slave (enable/flap/game_over in,
//                lights/row/crashed/state out, all outputs registered)
module bird_column import bird_pkg::*; #(
    parameter int ROWS          = 8,
    parameter int FLAP_ROWS     = 2,
    parameter int GRAVITY_TICKS = 3,
    parameter int START_ROW     = ROWS / 2
) (
    input  logic          clk,
    input  logic          reset,
    bird_column_if.slave  bus
);

    localparam int RW = ROW_W(ROWS);
    localparam logic [RW-1:0] TOP_ROW    = RW'(ROWS - 1);
    localparam logic [RW-1:0] START      = RW'(START_ROW);
    // at or above this row a flap hits the ceiling
    localparam logic [RW-1:0] LIFT_LIMIT = RW'(ROWS - 1 - FLAP_ROWS);
    localparam logic [RW-1:0] LIFT       = RW'(FLAP_ROWS);

    if (ROWS < 2) begin : gBadRows
        $error("bird_column: ROWS must be >= 2");
    end
    if (FLAP_ROWS < 1 || FLAP_ROWS >= ROWS) begin : gBadFlap
        $error("bird_column: FLAP_ROWS must be in [1, ROWS-1]");
    end
    if (GRAVITY_TICKS < 1) begin : gBadGravity
        $error("bird_column: GRAVITY_TICKS must be >= 1");
    end
    if (START_ROW < 0 || START_ROW >= ROWS) begin : gBadStart
        $error("bird_column: START_ROW must be in [0, ROWS-1]");
    end

    bird_state_t     state;
    logic            pending;
    logic            crashed;
    logic [RW-1:0]   row;
    logic [ROWS-1:0] lights;

    logic            flapNow;
    logic            fallDue;
    logic [RW-1:0]   lifted;

    // a flap in the same cycle as the tick counts for that tick
    assign flapNow = pending | bus.flap;
    assign lifted  = (row >= LIFT_LIMIT) ? TOP_ROW : row + LIFT;

    gravity_counter #(
        .GRAVITY_TICKS (GRAVITY_TICKS)
    ) uGravity (
        .clk      (clk),
        .reset    (reset),
        .tick     (bus.enable),
        .clear    (flapNow),
        .hold     ((state != FLY) | bus.game_over),
        .fall_due (fallDue)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pending <= 1'b0;
            crashed <= 1'b0;
            row     <= START;
            lights  <= ROWS'(1) << START_ROW;
        end else begin
            // any tick consumes the latch; flaps are meaningless once dead
            if (bus.game_over || state == DEAD || bus.enable) pending <= 1'b0;
            else if (bus.flap)                                 pending <= 1'b1;

            if (bus.game_over) begin
                state <= DEAD;
            end else if (bus.enable && state != DEAD) begin
                if (flapNow) begin
                    state  <= FLY;
                    row    <= lifted;
                    lights <= ROWS'(1) << lifted;
                end else if (fallDue) begin
                    if (row != '0) begin
                        row    <= row - 1'b1;
                        lights <= lights >> 1;
                    end else begin
                        crashed <= 1'b1;
                        state   <= DEAD;
                    end
                end
            end
        end
    end

    assign bus.state   = state;
    assign bus.crashed = crashed;
    assign bus.row     = row;
    assign bus.lights  = lights;

endmodule

// File: tb/tb_bird_column.sv
// Directed bench for bird_column (ROWS=8, FLAP_ROWS=2, GRAVITY_TICKS=3,
// START_ROW=4, enable pulsed every 4 clk).
module tb_bird_column;
    import bird_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bird_column_if #(.ROWS(8)) bus ();

    bird_column #(
        .ROWS          (8),
        .FLAP_ROWS     (2),
        .GRAVITY_TICKS (3),
        .START_ROW     (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          rst;      // reset before applying
        int          ticks;    // number of 4-clk tick periods
        bit          flapEarly;// flap 2 clk before each tick
        bit          flapSame; // flap in the tick cycle
        int          expRow;
        bird_state_t expState;
        bit          expCr;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic checkOut(input string name, input int expRow, input bird_state_t expState, input bit expCr);
        logic [31:0] expLights;
        expLights = 32'(1) << expRow;
        check({name, ".row"},     32'(bus.row),     32'(expRow));
        check({name, ".lights"},  32'(bus.lights),  expLights);
        check({name, ".state"},   32'(bus.state),   32'(expState));
        check({name, ".crashed"}, 32'(bus.crashed), 32'(expCr));
    endtask

    task automatic cyc(input bit en, input bit fl, input bit go);
        @(negedge clk);
        bus.enable    = en;
        bus.flap      = fl;
        bus.game_over = go;
        @(posedge clk);
        #1;
    endtask

    task automatic doTick(input bit fe, input bit fs);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, fe,   1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, fs,   1'b0);
    endtask

    task automatic doReset();
        @(negedge clk);
        bus.enable    = 1'b0;
        bus.flap      = 1'b0;
        bus.game_over = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bus.enable    = 1'b0;
        bus.flap      = 1'b0;
        bus.game_over = 1'b0;

        vecs[0]  = '{1'b1, 10, 1'b0, 1'b0, 4, IDLE, 1'b0};
        vecs[1]  = '{1'b0,  1, 1'b1, 1'b0, 6, FLY,  1'b0};
        vecs[2]  = '{1'b0,  2, 1'b0, 1'b0, 6, FLY,  1'b0};
        vecs[3]  = '{1'b0,  1, 1'b0, 1'b0, 5, FLY,  1'b0};
        vecs[4]  = '{1'b1,  1, 1'b0, 1'b1, 6, FLY,  1'b0};
        vecs[5]  = '{1'b0,  1, 1'b0, 1'b1, 7, FLY,  1'b0};
        vecs[6]  = '{1'b0,  1, 1'b0, 1'b1, 7, FLY,  1'b0};
        vecs[7]  = '{1'b0, 18, 1'b0, 1'b0, 1, FLY,  1'b0};
        vecs[8]  = '{1'b0,  3, 1'b0, 1'b0, 0, FLY,  1'b0};
        vecs[9]  = '{1'b0,  2, 1'b0, 1'b0, 0, FLY,  1'b0};
        vecs[10] = '{1'b0,  1, 1'b0, 1'b0, 0, DEAD, 1'b1};
        vecs[11] = '{1'b0,  3, 1'b1, 1'b1, 0, DEAD, 1'b1};

        doReset();
        #1;
        checkOut("reset", 4, IDLE, 1'b0);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].rst) doReset();
            for (int t = 0; t < vecs[i].ticks; t++)
                doTick(vecs[i].flapEarly, vecs[i].flapSame);
            checkOut($sformatf("vec%0d", i), vecs[i].expRow, vecs[i].expState, vecs[i].expCr);
        end

        // several flaps between ticks collapse to a single lift
        doReset();
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        checkOut("collapse", 6, FLY, 1'b0);
        doTick(1'b0, 1'b0);
        checkOut("collapse_next", 6, FLY, 1'b0);

        // game_over between ticks with a flap in the same cycle
        doReset();
        doTick(1'b0, 1'b1);
        repeat (3) doTick(1'b0, 1'b0);
        checkOut("go_pre", 5, FLY, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        checkOut("go_edge", 5, DEAD, 1'b0);
        repeat (2) doTick(1'b0, 1'b1);
        checkOut("go_frozen", 5, DEAD, 1'b0);

        // game_over wins over a flap tick on the same edge
        doReset();
        doTick(1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        checkOut("go_vs_tick", 6, DEAD, 1'b0);

        // asynchronous reset mid-clock while flying at row 2
        doReset();
        doTick(1'b0, 1'b1);
        repeat (12) doTick(1'b0, 1'b0);
        checkOut("pre_async", 2, FLY, 1'b0);
        #2 reset = 1'b1;
        #1;
        checkOut("async_rst", 4, IDLE, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        doTick(1'b0, 1'b1);
        checkOut("post_rst", 6, FLY, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
